// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle RV32I core.
// Sequences the shared ALU, memory port, register file and immediate extender.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       Illegal
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD,
    S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_LUI
  } state_t;

  state_t state_q, state_d;

  logic       f3_alu_ok;
  logic       legal;
  logic [2:0] alu_dec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    f3_alu_ok = (funct3 == 3'b000) || (funct3 == 3'b111) ||
                (funct3 == 3'b110) || (funct3 == 3'b010);
    unique case (op)
      OP_LW, OP_SW, OP_JAL, OP_LUI: legal = 1'b1;
      OP_R, OP_I:                   legal = f3_alu_ok;
      OP_BR:                        legal = (funct3[2:1] == 2'b00);
      default:                      legal = 1'b0;
    endcase
  end

  always_comb begin
    unique case (funct3)
      3'b000:  alu_dec = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_dec = ALU_AND;
      3'b110:  alu_dec = ALU_OR;
      3'b010:  alu_dec = ALU_SLT;
      default: alu_dec = ALU_ADD;
    endcase
  end

  always_comb begin
    unique case (op)
      OP_SW:   ImmSrc = 3'b001;
      OP_BR:   ImmSrc = 3'b010;
      OP_JAL:  ImmSrc = 3'b011;
      OP_LUI:  ImmSrc = 3'b100;
      default: ImmSrc = 3'b000;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    Illegal    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        if (!legal) begin
          Illegal = 1'b1;
          state_d = S_FETCH;
        end else begin
          unique case (op)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_R:         state_d = S_EXECR;
            OP_I:         state_d = S_EXECI;
            OP_BR:        state_d = S_BRANCH;
            OP_JAL:       state_d = S_JAL;
            default:      state_d = S_LUI;
          endcase
        end
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_dec;
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        // funct3[0] distinguishes bne from beq
        PCWrite    = Zero ^ funct3[0];
        state_d    = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_LUI: begin
        ResultSrc = 2'b11;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      Illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller.
// Each record holds one instruction's inputs and per-cycle expected outputs.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;

  int checks = 0;
  int errors = 0;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int         len;
    logic [17:0] exp [5];
  } vec_t;

  vec_t vecs[$];

  // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc,Illegal}
  function automatic logic [17:0] w(logic pc, logic adr, logic mw,
      logic ir, logic rw, logic [1:0] rs, logic [1:0] a, logic [1:0] b,
      logic [2:0] alu, logic [2:0] imm, logic ill);
    return {pc, adr, mw, ir, rw, rs, a, b, alu, imm, ill};
  endfunction

  function automatic logic [17:0] fw(logic [2:0] imm);
    return w(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0);
  endfunction

  function automatic logic [17:0] dw(logic [2:0] imm, logic ill);
    return w(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, ill);
  endfunction

  function automatic logic [17:0] act();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
            ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal};
  endfunction

  task automatic add(string n, logic [6:0] o, logic [2:0] f3, logic f7,
      logic z, int len, logic [17:0] e2, logic [17:0] e3, logic [17:0] e4,
      logic ill = 0);
    vec_t v;
    logic [2:0] imm;
    imm = (o == 7'b0100011) ? 3'b001 : (o == 7'b1100011) ? 3'b010 :
          (o == 7'b1101111) ? 3'b011 : (o == 7'b0110111) ? 3'b100 : 3'b000;
    v.name = n; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.len = len;
    v.exp[0] = fw(imm);
    v.exp[1] = dw(imm, ill);
    v.exp[2] = e2; v.exp[3] = e3; v.exp[4] = e4;
    vecs.push_back(v);
  endtask

  task automatic check(string n, int cyc, logic [17:0] e);
    checks++;
    if (act() !== e) begin
      errors++;
      $display("FAIL %s cyc %0d: got %b exp %b", n, cyc, act(), e);
    end
  endtask

  task automatic set_in(logic [6:0] o, logic [2:0] f3, logic f7, logic z);
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
  endtask

  logic [17:0] aluwb, x;

  initial begin
    aluwb = w(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0);
    x = '0;
    add("lw", 7'b0000011, 3'b010, 0, 0, 5,
        w(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0),
        w(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0),
        w(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0));
    add("sw", 7'b0100011, 3'b010, 0, 0, 4,
        w(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0),
        w(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 0), x);
    add("add", 7'b0110011, 3'b000, 0, 0, 4,
        w(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, 0), aluwb, x);
    add("sub", 7'b0110011, 3'b000, 1, 0, 4,
        w(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 0), aluwb, x);
    add("and", 7'b0110011, 3'b111, 0, 0, 4,
        w(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, 3'b000, 0), aluwb, x);
    add("or", 7'b0110011, 3'b110, 0, 0, 4,
        w(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b011, 3'b000, 0), aluwb, x);
    add("slt", 7'b0110011, 3'b010, 0, 0, 4,
        w(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b101, 3'b000, 0), aluwb, x);
    add("addi_f7", 7'b0010011, 3'b000, 1, 0, 4,
        w(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0), aluwb, x);
    add("andi", 7'b0010011, 3'b111, 0, 0, 4,
        w(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b010, 3'b000, 0), aluwb, x);
    add("beq_z1", 7'b1100011, 3'b000, 0, 1, 3,
        w(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0), x, x);
    add("bne_z1", 7'b1100011, 3'b001, 0, 1, 3,
        w(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0), x, x);
    add("beq_z0", 7'b1100011, 3'b000, 0, 0, 3,
        w(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0), x, x);
    add("bne_z0", 7'b1100011, 3'b001, 0, 0, 3,
        w(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 0), x, x);
    add("jal", 7'b1101111, 3'b000, 0, 0, 4,
        w(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b011, 0),
        w(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b011, 0), x);
    add("lui", 7'b0110111, 3'b000, 0, 0, 3,
        w(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 3'b000, 3'b100, 0), x, x);
    add("ill_op", 7'b1111111, 3'b000, 0, 0, 2, x, x, x, 1);
    add("ill_r_f3", 7'b0110011, 3'b001, 0, 0, 2, x, x, x, 1);
    add("ill_br_f3", 7'b1100011, 3'b100, 0, 1, 2, x, x, x, 1);
    add("lui_after", 7'b0110111, 3'b000, 0, 0, 3,
        w(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 3'b000, 3'b100, 0), x, x);

    rst = 1'b1;
    set_in(7'b0000000, 3'b000, 0, 0);
    repeat (3) begin
      @(negedge clk);
      #1 check("reset", 0, w(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0));
    end

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].len; c++) begin
        @(negedge clk);
        rst = 1'b0;
        set_in(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z);
        #1 check(vecs[i].name, c, vecs[i].exp[c]);
      end
    end

    // abort a load in MEMREAD with reset
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      set_in(7'b0000011, 3'b010, 0, 0);
      #1 check("lw_pre_rst", c, c == 0 ? fw(3'b000) : c == 1 ? dw(3'b000, 0) :
               w(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0));
    end
    @(negedge clk);
    #1 check("memread", 3, w(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
    #1 rst = 1'b1;
    #1 check("rst_mid", 0, w(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0));
    @(negedge clk);
    #1 check("rst_hold", 1, w(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0));
    @(negedge clk);
    rst = 1'b0;
    #1 check("post_rst_fetch", 0, fw(3'b000));
    @(negedge clk);
    #1 check("post_rst_decode", 1, dw(3'b000, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multi-cycle RV32I core. Decodes the instruction register fields and sequences the shared datapath: one ALU, one unified instruction/data memory port, register file and immediate extender. Each instruction takes 3–5 cycles. The block drives `ImmSrc` to the immediate extender using the extender's fixed encoding.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  — system clock, rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `op`  in  7  — `Instr[6:0]`.
- `funct3`  in  3  — `Instr[14:12]`.
- `funct7b5`  in  1  — `Instr[30]`.
- `Zero`  in  1  — ALU zero flag, same cycle.
- `PCWrite`  out  1  — PC register enable.
- `AdrSrc`  out  1  — memory address select: 0 = PC, 1 = Result.
- `MemWrite`  out  1  — data memory write strobe.
- `IRWrite`  out  1  — instruction and OldPC register enable.
- `RegWrite`  out  1  — register file write enable.
- `ResultSrc`  out  2  — 00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = ImmExt.
- `ALUSrcA`  out  2  — 00 = PC, 01 = OldPC, 10 = RD1.
- `ALUSrcB`  out  2  — 00 = RD2, 01 = ImmExt, 10 = constant 4.
- `ALUControl`  out  3  — 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `ImmSrc`  out  3  — 000 I, 001 S, 010 B, 011 J, 100 U.
- `Illegal`  out  1  — one-cycle pulse when DECODE sees an unsupported encoding.

## Operation
- Supported instructions:
  - lw (0000011)
  - sw (0100011)
  - R-type (0110011)
  - I-ALU (0010011)
  - beq/bne (1100011, funct3 000/001)
  - jal (1101111)
  - lui (0110111)
- `ImmSrc` is combinational from `op`:
  - lw and I-ALU → 000
  - sw → 001
  - branch → 010
  - jal → 011
  - lui → 100
  - anything else → 000
- ALU decode, used in EXEC_R, EXEC_I and BRANCH:
  - funct3 000 → add; sub when R-type with funct7b5=1; branch always sub.
  - funct3 111 → and; 110 → or; 010 → slt.
  - Any other funct3 on R or I, or branch funct3 other than 000/001, is illegal.
- Every state not listed below drives ALUControl = add. All unlisted strobes are 0 and all unlisted selects are 00.
- State actions:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, PCWrite=1 (PC ← PC+4).
  - DECODE: ALUSrcA=01, ALUSrcB=01 (ALUOut ← OldPC+imm, the branch/jal target).
  - MEMADR: ALUSrcA=10, ALUSrcB=01.
  - MEMREAD: ResultSrc=00, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
  - EXEC_R: ALUSrcA=10, ALUSrcB=00, decoded ALUControl.
  - EXEC_I: ALUSrcA=10, ALUSrcB=01, decoded ALUControl.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite = Zero XOR funct3[0].
  - JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1.
  - LUI: ResultSrc=11, RegWrite=1.
- Transitions:
  - FETCH → DECODE.
  - DECODE, by op: lw/sw → MEMADR; R → EXEC_R; I → EXEC_I; branch → BRANCH; jal → JAL; lui → LUI. Illegal encoding → FETCH with `Illegal`=1 for that DECODE cycle.
  - MEMADR → MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD → MEMWB.
  - EXEC_R, EXEC_I, JAL → ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH, LUI → FETCH.

## Timing
- The state register is the only storage. It is reset asynchronously to FETCH.
- Outputs are Moore, except three that are combinational from state plus inputs:
  - `PCWrite` in BRANCH (uses `Zero`).
  - `ImmSrc` (uses `op`).
  - `Illegal` (uses `op`/`funct3`).
- While `rst`=1, PCWrite, IRWrite, MemWrite, RegWrite and Illegal are forced to 0. The remaining outputs show their FETCH values.
- The first FETCH strobe occurs on the first rising edge after `rst` deasserts.
- Reset mid-instruction aborts it immediately. No partial write can occur after `rst` asserts.
- Cycles per instruction, FETCH inclusive: lw 5, sw 4, R 4, I 4, branch 3, jal 4, lui 3, illegal 2.
- `op`/`funct3`/`funct7b5` come from the IR and are valid from DECODE until the next FETCH.
- `Zero` must settle within the BRANCH cycle.

## Test plan
- Reset with `rst` high for 3 cycles, then release → all write strobes 0 during reset; IRWrite=1 and PCWrite=1 on the first cycle after release; state DECODE next.
- lw (op 0000011) → 5-cycle sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. ImmSrc=000. RegWrite=1 only in cycle 5 with ResultSrc=01.
- sw → MemWrite=1 only in cycle 4, with AdrSrc=1 and ImmSrc=001. RegWrite is never asserted.
- beq with Zero=1, then bne with Zero=1 → PCWrite=1 in BRANCH for beq only. ImmSrc=010 and ALUControl=001 in both cases.
- R-type sub (funct7b5=1, funct3 000) gives ALUControl=001. addi with funct7b5=1 gives ALUControl=000. jal gives ImmSrc=011, PCWrite in cycle 3, RegWrite in cycle 4. lui gives ImmSrc=100 and ResultSrc=11 in cycle 3.
- op 1111111 → `Illegal` pulses for one cycle in DECODE, then FETCH follows with no write strobes asserted. Asserting `rst` during MEMREAD returns the FSM to FETCH with MemWrite and RegWrite staying 0.
